// File: rtl/riscv_mem_responder_pkg.sv
// Shared constants for the RISC-V memory responder: funct3 codes, FSM
// state encodings and the legal wait-latency range.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Request/response port between the core's memory interface and the responder.
interface riscv_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/riscv_mem_responder_lsu_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension
// for loads; also flags misaligned accesses and illegal funct3 codes.
module riscv_lsu_align
    import riscv_mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] ldata,
    output logic        bad
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be       = 4'b0000;
        wdata_sh = 32'h0;
        ldata    = 32'h0;
        bad      = 1'b0;
        if (we) begin
            // Store data is replicated across lanes; be picks the live ones.
            unique case (funct3)
                F3_SB: begin
                    be       = 4'b0001 << addr_lo;
                    wdata_sh = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    bad      = addr_lo[0];
                    be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_sh = {2{wdata[15:0]}};
                end
                F3_SW: begin
                    bad      = (addr_lo != 2'b00);
                    be       = 4'b1111;
                    wdata_sh = wdata;
                end
                default: bad = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_LB:  ldata = {{24{sel_byte[7]}}, sel_byte};
                F3_LBU: ldata = {24'h0, sel_byte};
                F3_LH: begin
                    bad   = addr_lo[0];
                    ldata = {{16{sel_half[15]}}, sel_half};
                end
                F3_LHU: begin
                    bad   = addr_lo[0];
                    ldata = {16'h0, sel_half};
                end
                F3_LW: begin
                    bad   = (addr_lo != 2'b00);
                    ldata = rdata;
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            be    = 4'b0000;
            ldata = 32'h0;
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Fixed-latency unified word RAM responder for the multicycle RISC-V core.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency countdown; read registered / store committed at count 0
// RESP  | response held until rsp_ready
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_mem_responder_if.slave  bus
);

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("riscv_mem_responder: READ_LATENCY out of range");
    end

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    mem_state_t            state, state_nxt;
    logic [2:0]            cnt;
    logic                  cap_we;
    logic [ADDR_WIDTH+1:0] cap_addr;
    logic [2:0]            cap_funct3;
    logic [31:0]           cap_wdata;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic [31:0]           mem [DEPTH];

    logic        accept, acc_err, range_bad, done;
    logic        sel_we;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic [31:0] sel_wdata;
    logic [31:0] raw_word;
    logic [3:0]  be;
    logic [31:0] wdata_sh, ldata;
    logic        align_bad;

    // While idle the aligner checks the incoming request; afterwards it
    // works on the captured one.
    always_comb begin
        sel_we      = (state == IDLE) ? bus.req_we         : cap_we;
        sel_funct3  = (state == IDLE) ? bus.req_funct3     : cap_funct3;
        sel_addr_lo = (state == IDLE) ? bus.req_addr[1:0]  : cap_addr[1:0];
        sel_wdata   = (state == IDLE) ? bus.req_wdata      : cap_wdata;
        raw_word    = mem[cap_addr[ADDR_WIDTH+1:2]];
    end

    riscv_lsu_align u_align (
        .we       (sel_we),
        .funct3   (sel_funct3),
        .addr_lo  (sel_addr_lo),
        .wdata    (sel_wdata),
        .rdata    (raw_word),
        .be       (be),
        .wdata_sh (wdata_sh),
        .ldata    (ldata),
        .bad      (align_bad)
    );

    always_comb begin
        range_bad = |bus.req_addr[31:ADDR_WIDTH+2];
        acc_err   = align_bad | range_bad;
        accept    = bus.req_valid && bus.req_ready;
        done      = (state == WAIT) && (cnt == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = acc_err ? RESP : WAIT;
            WAIT: if (cnt == 3'd0) state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        bus.rsp_valid = (state == RESP);
        bus.busy      = (state != IDLE);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 3'd0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_funct3  <= 3'd0;
            cap_wdata   <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt         <= 3'(READ_LATENCY - 1);
                cap_we      <= bus.req_we;
                cap_addr    <= bus.req_addr[ADDR_WIDTH+1:0];
                cap_funct3  <= bus.req_funct3;
                cap_wdata   <= bus.req_wdata;
                rsp_rdata_q <= 32'h0;
                rsp_err_q   <= acc_err;
            end else if (state == WAIT) begin
                if (cnt != 3'd0) cnt <= cnt - 3'd1;
                if (done && !cap_we) rsp_rdata_q <= ldata;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_rdata_q <= 32'h0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    // No reset on the array; rst only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && done && cap_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[cap_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder with hand-computed expectations.
module tb_riscv_mem_responder;
    import riscv_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    riscv_mem_responder_if bus ();

    riscv_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns one time unit after the accept edge with request inputs scrambled.
    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_idle", {31'h0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_addr   = 32'h0000_0040;
        bus.req_funct3 = F3_LW;
        bus.req_wdata  = 32'h5555_5555;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat;
        int k;
        lat = 0;
        k   = 1;
        while (lat == 0 && k <= 12) begin
            chk({tag, "_rdy_busy"}, {31'h0, bus.req_ready}, 32'd0);
            if (bus.rsp_valid) lat = k;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        issue(we, a, f3, wd);
        wait_rsp(tag, exp_lat);
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {31'h0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'd0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_err",   {31'h0, bus.rsp_err}, 32'd0);
        chk("rst_busy",  {31'h0, bus.busy}, 32'd0);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: word store and load
        txn("sw10",  1'b1, 32'h10, F3_SW, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        txn("lw10",  1'b0, 32'h10, F3_LW, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        // 2: byte store, byte loads
        txn("sb13",  1'b1, 32'h13, F3_SB, 32'h000000AA, 32'h0, 1'b0, 3);
        txn("lb13",  1'b0, 32'h13, F3_LB,  32'h0, 32'hFFFFFFAA, 1'b0, 3);
        txn("lbu13", 1'b0, 32'h13, F3_LBU, 32'h0, 32'h000000AA, 1'b0, 3);
        txn("lw10b", 1'b0, 32'h10, F3_LW,  32'h0, 32'hAAADBEEF, 1'b0, 3);
        txn("lb10",  1'b0, 32'h10, F3_LB,  32'h0, 32'hFFFFFFEF, 1'b0, 3);

        // 3: halfword loads
        txn("lh12",  1'b0, 32'h12, F3_LH,  32'h0, 32'hFFFFAAAD, 1'b0, 3);
        txn("lhu12", 1'b0, 32'h12, F3_LHU, 32'h0, 32'h0000AAAD, 1'b0, 3);
        txn("lhu10", 1'b0, 32'h10, F3_LHU, 32'h0, 32'h0000BEEF, 1'b0, 3);
        txn("lh11",  1'b0, 32'h11, F3_LH,  32'h0, 32'h0, 1'b1, 1);

        // 4: error requests must not write
        txn("sw12",   1'b1, 32'h12,   F3_SW,  32'h11111111, 32'h0, 1'b1, 1);
        txn("lw1000", 1'b0, 32'h1000, F3_LW,  32'h0, 32'h0, 1'b1, 1);
        txn("ld011",  1'b0, 32'h10,   3'b011, 32'h0, 32'h0, 1'b1, 1);
        txn("st100",  1'b1, 32'h10,   3'b100, 32'h22222222, 32'h0, 1'b1, 1);
        txn("sh11",   1'b1, 32'h11,   F3_SH,  32'h33333333, 32'h0, 1'b1, 1);
        txn("lw10c",  1'b0, 32'h10,   F3_LW,  32'h0, 32'hAAADBEEF, 1'b0, 3);

        // 5: back-pressure, and a store offered during RESP must be ignored
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h10, F3_LW, 32'h0);
        wait_rsp("bp", 3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata", bus.rsp_rdata, 32'hAAADBEEF);
            chk("bp_err",   {31'h0, bus.rsp_err}, 32'd0);
            chk("bp_ready", {31'h0, bus.req_ready}, 32'd0);
            @(negedge clk);
            bus.req_valid  = (i == 2);
            bus.req_we     = 1'b1;
            bus.req_addr   = 32'h10;
            bus.req_funct3 = F3_SW;
            bus.req_wdata  = 32'h0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_busy",  {31'h0, bus.busy}, 32'd0);
        chk("bp_rel_valid", {31'h0, bus.rsp_valid}, 32'd0);
        txn("lw10d", 1'b0, 32'h10, F3_LW, 32'h0, 32'hAAADBEEF, 1'b0, 3);

        // 6: reset during WAIT discards the pending store
        txn("sw20z", 1'b1, 32'h20, F3_SW, 32'h00000000, 32'h0, 1'b0, 3);
        issue(1'b1, 32'h20, F3_SW, 32'h12345678);
        chk("mid_busy", {31'h0, bus.busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy",  {31'h0, bus.busy}, 32'd0);
        chk("mrst_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("mrst_err",   {31'h0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn("lw20", 1'b0, 32'h20, F3_LW, 32'h0, 32'h00000000, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
